// File: rtl/axi_burst_master.sv
// Single-burst AXI4 master: one local read/write command becomes one AXI4 burst.
// The command is checked for legality before any channel valid is raised.
module axi_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [1:0]            cmd_burst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BYTES - 1);

  typedef enum logic [2:0] {IDLE, CHECK, AW, W, B, AR, R, DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [1:0]        burst;
  } cmd_t;

  state_t      state, nxt;
  cmd_t        cmd_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic        illegal;
  logic        last_beat;
  logic [8:0]  beats;
  logic [31:0] span;
  logic        unused_resp;

  // Only the SLVERR/DECERR bit of a response matters to this master.
  assign unused_resp = ^{bresp[0], rresp[0]};

  assign beats     = {1'b0, cmd_q.len} + 9'd1;
  assign span      = 32'(cmd_q.addr[11:0]) + 32'(beats) * 32'(BYTES);
  assign last_beat = (cnt_q == cmd_q.len);

  always_comb begin
    illegal = 1'b0;
    if (32'(beats) > 32'(MAX_LEN))            illegal = 1'b1;
    if (|(cmd_q.addr & ADDR_MASK))            illegal = 1'b1;
    if (cmd_q.burst == 2'd3)                  illegal = 1'b1;
    if (cmd_q.burst == 2'd2 &&
        !(cmd_q.len inside {8'd1, 8'd3, 8'd7, 8'd15}))
                                              illegal = 1'b1;
    if (cmd_q.burst == 2'd0 && cmd_q.len > 8'd15) illegal = 1'b1;
    if (cmd_q.burst == 2'd1 && span > 32'd4096)   illegal = 1'b1;
  end

  // Address-channel fields come straight from the captured command, so they
  // are stable for the whole time awvalid/arvalid is held.
  assign awaddr  = cmd_q.addr;
  assign awlen   = cmd_q.len;
  assign awburst = cmd_q.burst;
  assign araddr  = cmd_q.addr;
  assign arlen   = cmd_q.len;
  assign arburst = cmd_q.burst;
  assign awsize  = 3'(SZ);
  assign arsize  = 3'(SZ);
  assign wstrb   = '1;
  assign err     = err_q;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt            = state;
    busy           = (state != IDLE);
    done           = 1'b0;
    awvalid        = 1'b0;
    arvalid        = 1'b0;
    wvalid         = 1'b0;
    wdata          = '0;
    wlast          = 1'b0;
    data_in_ready  = 1'b0;
    bready         = 1'b0;
    rready         = 1'b0;
    data_out       = '0;
    data_out_valid = 1'b0;
    case (state)
      IDLE:  if (start) nxt = CHECK;
      CHECK: nxt = illegal ? DONE : (cmd_q.wr ? AW : AR);
      AW: begin
        awvalid = 1'b1;
        if (awready) nxt = W;
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) nxt = R;
      end
      W: begin
        wvalid        = data_in_valid;
        wdata         = data_in;
        data_in_ready = wready;
        wlast         = last_beat;
        if (data_in_valid && wready && last_beat) nxt = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) nxt = DONE;
      end
      R: begin
        rready         = 1'b1;
        data_out       = rdata;
        data_out_valid = rvalid;
        // The counted beat ends the burst, whatever rlast says.
        if (rvalid && last_beat) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      cmd_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cmd_q <= '{wr: cmd_wr, addr: cmd_addr, len: cmd_len, burst: cmd_burst};
          cnt_q <= '0;
          err_q <= 1'b0;
        end
        CHECK: err_q <= illegal;
        W: if (wvalid && wready) cnt_q <= cnt_q + 8'd1;
        B: if (bvalid) err_q <= bresp[1];
        R: if (rvalid) begin
          cnt_q <= cnt_q + 8'd1;
          if (rresp[1] || (rlast && !last_beat)) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Parametrised AXI4 burst master, successor to the fixed-length `top` master. It accepts one read or write command at a time from the local side and issues a single AXI4 burst for it. The command sets length, burst type and address; the bus data width is a parameter. Illegal commands are rejected with an error before any bus traffic. It sits between the block-level controller and the AXI interconnect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width in bits; must be a power of 2, from 8 to 1024
- MAX_LEN, 16, maximum beats per burst, 1..256
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  asynchronous, active-low reset
- start  in  1  command strobe; accepted only while busy=0
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  8  beats minus 1
- cmd_burst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- data_in / data_in_valid / data_in_ready  in/in/out  DATA_W/1/1  write data stream
- data_out / data_out_valid  out  DATA_W/1  read data stream; no backpressure
- busy, done, err  out  1 each  status
- awaddr, araddr  out  ADDR_W ; awlen, arlen  out  8 ; awsize, arsize  out  3  = log2(DATA_W/8) ; awburst, arburst  out  2
- awvalid/awready, arvalid/arready, wvalid/wready  out/in  1  channel handshakes
- wdata  out  DATA_W ; wstrb  out  DATA_W/8  all ones ; wlast  out  1
- bresp  in  2 ; bvalid  in  1 ; bready  out  1
- rdata  in  DATA_W ; rresp  in  2 ; rlast  in  1 ; rvalid  in  1 ; rready  out  1

## Operation
- **States:** IDLE, CHECK, AW, W, B, AR, R, DONE.
- **IDLE:** when start=1 and busy=0, register all cmd_* inputs and go to CHECK. start while busy=1 is ignored.
- **CHECK (1 cycle):** the command is illegal if any of the following holds:
  - cmd_len+1 > MAX_LEN
  - cmd_addr is not aligned to DATA_W/8
  - cmd_burst = 3
  - WRAP with cmd_len+1 not in {2, 4, 8, 16}
  - FIXED with cmd_len > 15
  - INCR where addr[11:0] + (cmd_len+1)·(DATA_W/8) > 4096 (crosses a 4 KB boundary)
- **Illegal command:** go to DONE with err=1. No valid is raised on any AXI channel.
- **Legal command:** go to AW if cmd_wr=1, otherwise AR.
- **AW / AR:** hold awvalid/arvalid with stable address fields until ready. Then go to W (write) or R (read).
- **W:**
  - wdata = data_in; wvalid = data_in_valid; data_in_ready = wready (all combinational, W state only).
  - Beat counter increments on each wvalid&wready.
  - wlast = 1 while counter = cmd_len.
  - After the last beat, go to B.
- **B:** bready=1. On bvalid, err = bresp[1], then go to DONE.
- **R:**
  - rready=1; data_out = rdata; data_out_valid = rvalid & rready.
  - Count beats.
  - Set sticky err if any rresp[1]=1, or if rlast=1 on a beat other than beat cmd_len. The burst still ends on the counted beat cmd_len, whether or not rlast arrives.
  - Then go to DONE.
- **DONE:** done=1 for one cycle, then IDLE. err holds its value until the next command is accepted, then clears.
- **Output encodings:** awlen/arlen = cmd_len; awsize/arsize = log2(DATA_W/8) constant; awburst/arburst = cmd_burst.

## Timing
- **Reset values:** while areset=0, state = IDLE and every output is 0 except the constant awsize, arsize and wstrb. This includes all valids, readies, wlast, busy, done and err.
- **Reset mid-burst:** the transaction is abandoned immediately, with no completion pulse.
- **busy:** 1 from the cycle after start is accepted through the DONE cycle inclusive.
- **Start latency:** with start sampled at edge 0, CHECK occupies cycle 1 and awvalid/arvalid rise in cycle 2.
- **Completion latency:** done asserts in the cycle after the bvalid handshake (write) or the final R beat (read).
- **Back-to-back commands:** the minimum gap between accepted commands is 1 idle cycle after done.
- **W ordering:** W beats never start before the AW handshake completes.
- **Stalls:** wvalid low is permitted between beats. awvalid/arvalid, once raised, stay high until accepted.

## Test plan
- **INCR write:** write, addr 0x0000_0010, len 3, DATA_W=32, zero-wait slave, data 1..4 → one AW (awlen=3, awburst=1), wlast only on beat 4, done in cycle 8 after start, err=0.
- **WRAP read with bad rresp:** read, WRAP, len 7, rresp=SLVERR on beat 5 → 8 data_out_valid pulses carry rdata in order, done with err=1.
- **Illegal commands:** INCR addr 0x0FF8, len 3, DATA_W=32 (crosses 4 KB); also WRAP len 2 (3 beats) and cmd_burst=3 → no awvalid/arvalid ever, done with err=1 two cycles after start.
- **Backpressure:** wready and data_in_valid toggled randomly over a 16-beat write; arready delayed 5 cycles on a read → every beat transferred exactly once in order, wlast only on the 16th.
- **Protocol edge cases:** start pulsed while busy is ignored (no second transaction). Early rlast on beat 2 of 4 sets err; the remaining beats are still accepted.
- **Mid-burst reset:** areset low during beat 2 of a write → all outputs 0 asynchronously; a new command after release completes normally.
